// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the parametrised synchronous FIFO:
//   - ptr_w()      : pointer / count width for a given depth (address bits + wrap bit)
//   - RST_*        : reset values of the single-bit control outputs
// -----------------------------------------------------------------------------
package fifo_pkg;

    // Pointer width: AW address bits plus one wrap bit, AW = clog2(depth).
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam logic RST_EMPTY        = 1'b1;
    localparam logic RST_FULL         = 1'b0;
    localparam logic RST_ALMOST_EMPTY = 1'b1;
    localparam logic RST_ALMOST_FULL  = 1'b0;
    localparam logic RST_RD_VALID     = 1'b0;
    localparam logic RST_ERR_FLAG     = 1'b0;

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Simple dual-port RAM, DEPTH x WIDTH, synchronous write, registered read.
// The storage array is not reset; only the read-data register is.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset of the read-data register
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe; rd_data loads mem[rd_addr] on the edge
//   rd_addr  : read address
//   rd_data  : registered read data, held while rd_en is low
// -----------------------------------------------------------------------------
module fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Same-address read and write in one cycle returns the old word, which is
    // exactly the oldest entry when the FIFO is full and both sides move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with registered read, occupancy count,
// almost-full / almost-empty thresholds and synchronous flush.
// Optional feature macro: SYNC_FIFO_ERR_EN adds sticky overflow/underflow
// flags and their err_clr input.
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   flush           : synchronous clear of pointers, count and rd_valid
//   wr_en, wr_data  : write request and data
//   rd_en           : read request
//   rd_data         : registered read data, held until the next accepted read
//   rd_valid        : one-cycle pulse, rd_data valid this cycle
//   full, empty     : occupancy flags
//   almost_full     : count >= AFULL_TH
//   almost_empty    : count <= AEMPTY_TH
//   count           : occupancy 0..DEPTH
//   err_clr         : clear sticky flags         (SYNC_FIFO_ERR_EN only)
//   overflow        : sticky rejected-write flag (SYNC_FIFO_ERR_EN only)
//   underflow       : sticky rejected-read flag  (SYNC_FIFO_ERR_EN only)
// -----------------------------------------------------------------------------
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 9,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count
`ifdef SYNC_FIFO_ERR_EN
    ,
    input  logic                   err_clr,
    output logic                   overflow,
    output logic                   underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    localparam logic [PW-1:0] DEPTH_V  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_V  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_V = PW'(AEMPTY_TH);

    // Elaboration-time parameter legality checks.
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_param: WIDTH must be at least 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two, at least 2");
    end
    if (AFULL_TH < 0 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("sync_fifo_param: AFULL_TH must be within 0..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH) begin : g_bad_aempty
        $error("sync_fifo_param: AEMPTY_TH must be within 0..DEPTH");
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          rd_accept;
    logic          wr_accept;

    // Wrap-bit pointers: the modular difference is the occupancy directly.
    assign count        = wr_ptr - rd_ptr;
    assign full         = (count == DEPTH_V);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_V);
    assign almost_empty = (count <= AEMPTY_V);

    // Flush overrides both requests. A read frees the slot a write needs
    // when full; there is no bypass when empty.
    assign rd_accept = rd_en && !empty && !flush;
    assign wr_accept = wr_en && (!full || rd_accept) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= RST_RD_VALID;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            rd_valid <= rd_accept;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

`ifdef SYNC_FIFO_ERR_EN
    logic ovf_set;
    logic unf_set;

    // A request suppressed by flush is not counted as an error.
    assign ovf_set = wr_en && !flush && !wr_accept;
    assign unf_set = rd_en && !flush && !rd_accept;

    // A new error wins over err_clr in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= RST_ERR_FLAG;
            underflow <= RST_ERR_FLAG;
        end else begin
            overflow  <= ovf_set || (overflow  && !err_clr);
            underflow <= unf_set || (underflow && !err_clr);
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

    localparam int WIDTH     = 9;
    localparam int DEPTH     = 8;
    localparam int AFULL_TH  = DEPTH - 2;
    localparam int AEMPTY_TH = 1;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic                   wr_en;
    logic [WIDTH-1:0]       wr_data;
    logic                   rd_en;
    logic [WIDTH-1:0]       rd_data;
    logic                   rd_valid;
    logic                   full;
    logic                   empty;
    logic                   almost_full;
    logic                   almost_empty;
    logic [$clog2(DEPTH):0] count;
    logic                   err_clr;
`ifdef SYNC_FIFO_ERR_EN
    logic                   overflow;
    logic                   underflow;
`endif

    sync_fifo_param #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue holding the FIFO contents in order.
    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] m_rdata;
    logic             m_rvld;
    logic             m_ovf;
    logic             m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rdata = '0;
        m_rvld  = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic check_outputs(input string ctx);
        int n;
        n = q.size();
        chk({ctx, " count"},        32'(count),        32'(n));
        chk({ctx, " full"},         32'(full),         32'(n == DEPTH));
        chk({ctx, " empty"},        32'(empty),        32'(n == 0));
        chk({ctx, " almost_full"},  32'(almost_full),  32'(n >= AFULL_TH));
        chk({ctx, " almost_empty"}, 32'(almost_empty), 32'(n <= AEMPTY_TH));
        chk({ctx, " rd_valid"},     32'(rd_valid),     32'(m_rvld));
        chk({ctx, " rd_data"},      32'(rd_data),      32'(m_rdata));
`ifdef SYNC_FIFO_ERR_EN
        chk({ctx, " overflow"},     32'(overflow),     32'(m_ovf));
        chk({ctx, " underflow"},    32'(underflow),    32'(m_unf));
`endif
    endtask

    // One clock cycle: apply inputs, advance the model, check after the edge.
    task automatic step(input string ctx, input logic w, input logic [WIDTH-1:0] d,
                        input logic r, input logic f, input logic ec);
        logic rd_ok;
        logic wr_ok;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        err_clr = ec;
        rd_ok = 1'b0;
        wr_ok = 1'b0;
        if (f) begin
            q.delete();
            m_rvld = 1'b0;
        end else begin
            rd_ok = r && (q.size() > 0);
            wr_ok = w && ((q.size() < DEPTH) || rd_ok);
            if (rd_ok) m_rdata = q.pop_front();
            m_rvld = rd_ok;
            if (wr_ok) q.push_back(d);
        end
        if (ec) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (!f && w && !wr_ok) m_ovf = 1'b1;
        if (!f && r && !rd_ok) m_unf = 1'b1;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        err_clr = 1'b0;
        check_outputs(ctx);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        flush   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_outputs("reset");
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // Fill with 0x001..0x008, then one write too many.
        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
        step("overflow_wr", 1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0);

        // Drain in order, then one read too many.
        for (int i = 1; i <= DEPTH; i++) begin
            step("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
            chk("drain order", 32'(rd_data), 32'(i));
        end
        step("underflow_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("err_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Full with simultaneous read and write across pointer wrap.
        for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, WIDTH'(9'h100 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("full_rw", 1'b1, WIDTH'(9'h120 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Empty with simultaneous read and write: write only.
        step("empty_rw", 1'b1, 9'h055, 1'b1, 1'b0, 1'b0);
        step("empty_rw_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Flush with a concurrent write at count 5.
        for (int i = 0; i < 5; i++) step("pre_flush", 1'b1, WIDTH'(9'h0A0 + i), 1'b0, 1'b0, 1'b0);
        step("pre_flush_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("pre_flush_wr", 1'b1, 9'h0B0, 1'b0, 1'b0, 1'b0);
        step("flush", 1'b1, 9'h077, 1'b0, 1'b1, 1'b0);
        chk("flush rd_data held", 32'(rd_data), 32'(9'h0A0));

        // Reset arriving between a read request and the next edge.
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, WIDTH'(9'h0C0 + i), 1'b0, 1'b0, 1'b0);
        rd_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        chk("async_rst rd_valid after edge", 32'(rd_valid), 32'd0);
        chk("async_rst count after edge", 32'(count), 32'd0);
        rd_en = 1'b0;
        rst   = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic w, r, f, ec;
            w  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 50);
            f  = ($urandom_range(0, 63) == 0);
            ec = ($urandom_range(0, 15) == 0);
            step("rand", w, WIDTH'($urandom), r, f, ec);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO with registered read, occupancy count, programmable almost-full/almost-empty thresholds, and synchronous flush. It is the general-purpose buffering block between producer and consumer stages in the datapath and replaces fixed 8x9 FIFO instances. Read and write may occur in the same cycle, and overflow and underflow attempts are rejected safely.

## Interface
- WIDTH, 9: data word width in bits, at least 1.
- DEPTH, 8: number of entries; power of two, at least 2.
- AFULL_TH, DEPTH-2: `almost_full` asserts when count >= AFULL_TH.
- AEMPTY_TH, 1: `almost_empty` asserts when count <= AEMPTY_TH.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of pointers, count and `rd_valid`.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request.
- rd_data  out  WIDTH  registered read data.
- rd_valid  out  1  one-cycle pulse; `rd_data` is valid this cycle.
- full / empty  out  1  occupancy flags.
- almost_full / almost_empty  out  1  threshold flags.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow / underflow  out  1  sticky error flags (present only with `SYNC_FIFO_ERR_EN`).
- err_clr  in  1  synchronous clear of the sticky flags (present only with `SYNC_FIFO_ERR_EN`).

## Operation
- Pointers are AW+1 bits wide, where AW = $clog2(DEPTH). The low AW bits address memory; the MSB is the wrap bit. `count` = wr_ptr - rd_ptr, modulo 2^(AW+1).
- `full` is asserted when count == DEPTH. `empty` is asserted when count == 0. Both flags and both threshold flags decode from registered pointers, with no combinational path from `wr_en` or `rd_en`.
- Write accept condition: wr_en && (!full || rd_accept). Read accept condition: rd_en && !empty.
- Full, with `wr_en` and `rd_en` both asserted: both are accepted and count is unchanged.
- Empty, with both asserted: the write is accepted and the read is rejected. There is no write-to-read bypass.
- A write request while full, or a read request while empty, is rejected. Pointers, memory and `rd_data` are untouched.
- Pointers wrap naturally at 2^(AW+1); no special case is needed.
- `flush` has priority over `wr_en` and `rd_en` in the same cycle. It zeroes the pointers, drives `rd_valid` to 0 next cycle, and holds `rd_data`. Memory contents are not cleared.
- Reset values: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, rd_data 0, rd_valid 0, overflow 0, underflow 0. Memory is not reset.
- Reset asserted mid-operation returns the block immediately to the reset values. Any in-flight read is lost.

## Timing
- Write latency: data written at edge N is readable starting at edge N+1. `empty` deasserts after edge N.
- Read latency is 1 cycle: a read accepted at edge N gives `rd_data` and `rd_valid` = 1 after edge N. `rd_data` holds its value until the next accepted read.
- Flags and `count` update on the same edge as the accepted operation.

## Configuration
- `SYNC_FIFO_ERR_EN` defined:
  - `overflow` sets on any rejected write request; `underflow` sets on any rejected read request.
  - Both flags hold until `err_clr` or `rst`.
  - If `err_clr` and a new error occur in the same cycle, the flag stays set.
- `SYNC_FIFO_ERR_EN` undefined:
  - The `overflow`, `underflow` and `err_clr` ports and their logic are absent.
  - Rejection behaviour is otherwise identical.

## Structure
- Shared package `fifo_pkg` holds the pointer-width helper function and the reset constants. Parameter legality checks (power-of-two DEPTH, thresholds within 0..DEPTH) are elaboration-time assertions in the top module.
- Sub-module `fifo_mem`: a simple dual-port RAM, DEPTH x WIDTH, with synchronous write and synchronous registered read. The top module holds pointers, flags, count and error logic.

## Test plan
- Reset with defaults, then write 0x001..0x008 -> `full`=1, `count`=8, `almost_full` set from count 6. A ninth write of 0x1FF is dropped and `overflow`=1 (with macro).
- Read 8 times -> `rd_data` is 0x001..0x008 in order, each one cycle after its accept. `empty`=1 after the last read. A further read gives no `rd_valid` and `underflow`=1.
- Simultaneous read and write while full, 20 cycles -> `count` stays 8, data order is preserved across pointer wrap, and `full` never drops.
- Simultaneous read and write while empty -> write accepted, `rd_valid`=0, `count`=1 next cycle.
- `flush` with `wr_en`=1 at count 5 -> `count`=0, `empty`=1, the write is discarded, and `rd_data` holds its last value.
- `rst` asserted between `rd_en` accept and the next edge -> all outputs take their reset values asynchronously, and `rd_valid` never pulses.
